// File: rtl/load_store_unit.sv
// Load/store unit: one memory op per request over a req/ack word port,
// returning lane-aligned, sign/zero-extended load data.
module load_store_unit #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        memWrite,
    input  logic [2:0]  loadCtrl,
    input  logic [1:0]  storeCtrl,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic        busy,
    output logic        rspValid,
    output logic        rspError,
    output logic [31:0] rspData,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    input  logic        memAck,
    input  logic [31:0] memRdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  waitCnt;
    logic        isWrite;
    logic        isUnsigned;
    logic [1:0]  size;
    logic [1:0]  lane;

    logic [1:0]  reqSize;
    logic        reqLegal;
    logic        reqMisaligned;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;

    logic [31:0] shifted;
    logic [15:0] laneHalf;
    logic [31:0] loadData;

    assign reqReady = (state == IDLE);

    // Size encoding is shared: 0 byte, 1 half, 2 word, 3 illegal.
    always_comb begin
        reqSize = memWrite ? storeCtrl : loadCtrl[1:0];
        reqLegal = memWrite ? (storeCtrl != 2'b11)
                            : (loadCtrl[1:0] != 2'b11) && !(loadCtrl[2] && loadCtrl[1]);
        reqMisaligned = 1'b0;
        reqBe = 4'b1111;
        reqWdata = writeData;
        unique case (1'b1)
            (reqSize == 2'd0): begin
                reqBe = 4'b0001 << address[1:0];
                reqWdata = {4{writeData[7:0]}};
            end
            (reqSize == 2'd1): begin
                reqBe = 4'b0011 << {address[1], 1'b0};
                reqWdata = {2{writeData[15:0]}};
                reqMisaligned = address[0];
            end
            default: begin
                reqMisaligned = |address[1:0];
            end
        endcase
        if (!memWrite) begin
            reqWdata = 32'd0;
        end
    end

    always_comb begin
        shifted = memRdata >> {lane, 3'b000};
        laneHalf = lane[1] ? memRdata[31:16] : memRdata[15:0];
        loadData = memRdata;
        unique case (1'b1)
            (size == 2'd0):
                loadData = {{24{~isUnsigned & shifted[7]}}, shifted[7:0]};
            (size == 2'd1):
                loadData = {{16{~isUnsigned & laneHalf[15]}}, laneHalf};
            default:
                loadData = memRdata;
        endcase
        if (isWrite) begin
            loadData = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            waitCnt    <= 8'd0;
            isWrite    <= 1'b0;
            isUnsigned <= 1'b0;
            size       <= 2'd0;
            lane       <= 2'd0;
            busy       <= 1'b0;
            rspValid   <= 1'b0;
            rspError   <= 1'b0;
            rspData    <= 32'd0;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= 32'd0;
            memBe      <= 4'd0;
            memWdata   <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (reqValid) begin
                        isWrite    <= memWrite;
                        isUnsigned <= loadCtrl[2];
                        size       <= reqSize;
                        lane       <= address[1:0];
                        waitCnt    <= 8'd0;
                        busy       <= 1'b1;
                        if (reqLegal && !reqMisaligned) begin
                            state    <= ACCESS;
                            memReq   <= 1'b1;
                            memWe    <= memWrite;
                            memAddr  <= {address[31:2], 2'b00};
                            memBe    <= reqBe;
                            memWdata <= reqWdata;
                        end else begin
                            state    <= ERR;
                            rspValid <= 1'b1;
                            rspError <= 1'b1;
                            rspData  <= 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (memAck) begin
                        state    <= RESP;
                        memReq   <= 1'b0;
                        memWe    <= 1'b0;
                        rspValid <= 1'b1;
                        rspError <= 1'b0;
                        rspData  <= loadData;
                    end else if (waitCnt == LAST_WAIT) begin
                        state    <= ERR;
                        waitCnt  <= waitCnt + 8'd1;
                        memReq   <= 1'b0;
                        memWe    <= 1'b0;
                        rspValid <= 1'b1;
                        rspError <= 1'b1;
                        rspData  <= 32'd0;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rspValid <= 1'b0;
                    rspError <= 1'b0;
                    rspData  <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit with a reference model
// and a latency-programmable memory responder.
module tb_load_store_unit;

    localparam int T = 4;

    typedef struct {
        bit          err;
        logic [31:0] data;
        int          cycles;
        int          at;
    } rsp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mop_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        memWrite = 1'b0;
    logic [2:0]  loadCtrl = 3'd0;
    logic [1:0]  storeCtrl = 2'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] writeData = 32'd0;
    logic        busy;
    logic        rspValid;
    logic        rspError;
    logic [31:0] rspData;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = 32'd0;

    load_store_unit #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rstn(rstn),
        .reqValid(reqValid), .reqReady(reqReady),
        .memWrite(memWrite), .loadCtrl(loadCtrl), .storeCtrl(storeCtrl),
        .address(address), .writeData(writeData),
        .busy(busy), .rspValid(rspValid), .rspError(rspError), .rspData(rspData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memBe(memBe),
        .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    rsp_t rspQ[$];
    mop_t mopQ[$];
    int planLat = 0;
    logic [31:0] planRdata = 32'd0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Reference model from byte counts and offsets.
    function automatic void model(input bit wr, input logic [2:0] lc,
                                  input logic [1:0] sc, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  input int lat, output bit ok,
                                  output mop_t m, output rsp_t r);
        int nbytes;
        int off;
        bit legal;
        bit sgn;
        longint v;
        nbytes = 4;
        sgn = 1'b0;
        if (wr) begin
            legal = (sc != 2'd3);
            if (legal) nbytes = 1 << sc;
        end else begin
            legal = lc inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            if (legal) nbytes = 1 << lc[1:0];
            sgn = (lc < 3'd4);
        end
        off = int'(a % 4);
        ok = legal && (off % nbytes == 0);
        m.we = wr;
        m.addr = a - 32'(off);
        m.be = 4'(((1 << nbytes) - 1) << off);
        m.wdata = 32'd0;
        for (int i = 0; i < 4; i++)
            if (wr) m.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        v = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * nbytes)) - 1);
        if (sgn && v >= (longint'(1) << (8 * nbytes - 1)))
            v = v - (longint'(1) << (8 * nbytes));
        r.cycles = 0;
        r.at = 0;
        if (!ok) begin
            r.err = 1'b1;
            r.data = 32'd0;
        end else begin
            r.cycles = (lat < T) ? lat + 1 : T;
            r.err = (lat >= T);
            r.data = (wr || r.err) ? 32'd0 : v[31:0];
        end
    endfunction

    // Memory responder: acks in the planned memReq cycle, random noise otherwise.
    int reqCnt = 0;
    always @(negedge clk) begin
        if (memReq) begin
            if (reqCnt == planLat) begin
                memAck = 1'b1;
                memRdata = planRdata;
            end else begin
                memAck = 1'b0;
                memRdata = $urandom;
            end
            reqCnt++;
        end else begin
            reqCnt = 0;
            memAck = ($urandom % 4 == 0);
            memRdata = $urandom;
        end
    end

    // Monitor: pops expected memory ops and responses as the DUT presents them.
    logic prevReq = 1'b0;
    int reqCycles = 0;
    always @(negedge clk) begin
        mop_t m;
        rsp_t r;
        if (!rstn) begin
            prevReq = 1'b0;
            reqCycles = 0;
        end else begin
            if (memReq && !prevReq) begin
                reqCycles = 0;
                if (mopQ.size() == 0) begin
                    fail("unexpected memReq");
                end else begin
                    m = mopQ.pop_front();
                    chk("memWe", 32'(memWe), 32'(m.we));
                    chk("memAddr", memAddr, m.addr);
                    chk("memBe", 32'(memBe), 32'(m.be));
                    chk("memWdata", memWdata, m.wdata);
                end
            end
            if (memReq) reqCycles++;
            if (rspValid) begin
                if (rspQ.size() == 0) begin
                    fail("unexpected rspValid");
                end else begin
                    r = rspQ.pop_front();
                    chk("rspError", 32'(rspError), 32'(r.err));
                    chk("rspData", rspData, r.data);
                    chk("rspCycle", cyc, r.at);
                    chk("memReqCycles", reqCycles, r.cycles);
                end
                reqCycles = 0;
            end
            prevReq = memReq;
        end
    end

    task automatic issue(input bit wr, input logic [2:0] lc, input logic [1:0] sc,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int lat, input logic [31:0] rd);
        int guard;
        bit ok;
        mop_t m;
        rsp_t r;
        guard = 0;
        @(negedge clk);
        while (!reqReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!reqReady) begin
            fail("reqReady wait expired");
            return;
        end
        model(wr, lc, sc, a, wd, rd, lat, ok, m, r);
        r.at = cyc + 1 + r.cycles;
        if (ok) mopQ.push_back(m);
        rspQ.push_back(r);
        planLat = lat;
        planRdata = rd;
        reqValid = 1'b1;
        memWrite = wr;
        loadCtrl = lc;
        storeCtrl = sc;
        address = a;
        writeData = wd;
        @(negedge clk);
        // Junk request while busy must be dropped.
        memWrite = 1'($urandom);
        loadCtrl = 3'($urandom);
        storeCtrl = 2'($urandom);
        address = $urandom;
        writeData = $urandom;
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst reqReady", 32'(reqReady), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst memReq", 32'(memReq), 32'd0);
        chk("rst memWe", 32'(memWe), 32'd0);
        chk("rst rspValid", 32'(rspValid), 32'd0);
        chk("rst rspError", 32'(rspError), 32'd0);
        chk("rst rspData", rspData, 32'd0);
        chk("rst memAddr", memAddr, 32'd0);
        chk("rst memBe", 32'(memBe), 32'd0);
        chk("rst memWdata", memWdata, 32'd0);
        rstn = 1'b1;

        issue(1'b0, 3'b000, 2'd0, 32'h0000_1003, 32'd0, 0, 32'h80FF_1234);
        issue(1'b0, 3'b101, 2'd0, 32'h0000_2002, 32'd0, 3, 32'hBEEF_0000);
        issue(1'b1, 3'b000, 2'b00, 32'h0000_0010, 32'h1234_56AB, 1, 32'd0);
        issue(1'b1, 3'b000, 2'b10, 32'h0000_0022, 32'd0, 0, 32'd0);
        issue(1'b0, 3'b001, 2'd0, 32'h0000_0101, 32'd0, 0, 32'd0);
        issue(1'b0, 3'b011, 2'd0, 32'h0000_0100, 32'd0, 0, 32'd0);
        issue(1'b1, 3'b000, 2'b11, 32'h0000_0200, 32'hFFFF_FFFF, 0, 32'd0);
        issue(1'b0, 3'b010, 2'd0, 32'h0000_0300, 32'd0, 99, 32'd0);
        issue(1'b1, 3'b000, 2'b01, 32'h0000_0402, 32'hCAFE_5A5A, 2, 32'd0);

        // Reset in the middle of an access.
        issue(1'b0, 3'b010, 2'd0, 32'h0000_0040, 32'd0, 1000, 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst memReq", 32'(memReq), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst rspValid", 32'(rspValid), 32'd0);
        chk("midrst reqReady", 32'(reqReady), 32'd1);
        rstn = 1'b1;
        rspQ.delete();
        repeat (6) @(negedge clk);
        issue(1'b0, 3'b010, 2'd0, 32'h0000_0044, 32'd0, 2, 32'hDEAD_BEEF);

        for (int i = 0; i < 300; i++) begin
            int lat;
            lat = ($urandom % 8 == 0) ? T + int'($urandom % 3) : int'($urandom % T);
            issue(1'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom,
                  lat, $urandom);
        end

        guard = 0;
        while (rspQ.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (rspQ.size() != 0) fail("response drain expired");
        if (mopQ.size() != 0) fail("memory ops never issued");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Consumer-side counterpart of the control unit's memory controls. Takes loadCtrl/storeCtrl, memWrite, the ALU address and rs2 data. Runs one load or store per request against a single-port, word-addressed data memory with a req/ack handshake. Returns aligned, sign/zero-extended load data to the writeback path, and stalls the pipeline while busy.

Parameters:
ACK_TIMEOUT, 16, max cycles memReq stays high without memAck before the access aborts with error (range 1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  synchronous active-low reset
reqValid  input  1  pipeline presents a memory op this cycle
reqReady  output  1  unit can accept a request (IDLE only)
memWrite  input  1  1 = store, 0 = load (from control unit)
loadCtrl  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
storeCtrl  input  2  00 SB, 01 SH, 10 SW; 11 illegal
address  input  32  byte address from ALU
writeData  input  32  store data (rs2)
busy  output  1  state != IDLE (pipeline stall)
rspValid  output  1  one-cycle completion pulse
rspError  output  1  qualifies rspValid: misaligned, illegal ctrl or timeout
rspData  output  32  extended load data; 0 for stores and errors
memReq  output  1  memory request, held until ack
memWe  output  1  write enable, valid with memReq
memAddr  output  32  {address[31:2],2'b00}
memBe  output  4  byte lane enables
memWdata  output  32  lane-replicated store data
memAck  input  1  memory accepts/completes the access this cycle
memRdata  input  32  read word, valid when memAck=1 and memWe=0

Behaviour:
- States: IDLE, ACCESS, RESP, ERR. Registered outputs only; nothing combinational from input to output except reqReady = (state==IDLE).
- Reset (rstn=0 at an edge): state IDLE. memReq, memWe, rspValid, rspError, busy = 0. rspData, memAddr, memWdata, memBe = 0. Timeout counter = 0. Applies mid-access too: memReq drops at that edge and no response is issued.
- IDLE: on reqValid=1, latch memWrite, ctrl, address and writeData.
  - Legal and aligned: go to ACCESS.
  - Otherwise: go to ERR, with no memory request.
- Misaligned: halfword with address[0]=1; word with address[1:0]!=0. Byte accesses are never misaligned.
- ACCESS: memReq=1, memWe = latched memWrite, memAddr word-aligned.
  - memBe: byte = 0001<<a[1:0]; half = 0011<<{a[1],1'b0}; word = 1111. Same masks for loads.
  - memWdata: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd. 0 for loads.
  - Counter increments each ACCESS cycle without memAck.
  - memAck=1: capture memRdata, go to RESP. memReq deasserts the next cycle.
  - Counter reaching ACK_TIMEOUT without ack: go to ERR, memReq=0.
- RESP: rspValid=1, rspError=0 for exactly one cycle, then IDLE.
  - rspData selects the lane at address[1:0] (half: address[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW full word; store gives 0.
- ERR: rspValid=1, rspError=1, rspData=0 for one cycle, then IDLE.
- Minimum latency: request accepted at edge N, memReq high N..N+1. If memAck arrives in the first ACCESS cycle, rspValid is high in cycle N+2; reqReady returns in cycle N+3.
- memAck outside ACCESS: ignored. reqValid while busy: ignored, not queued.
- memAck arriving in the same cycle the counter hits ACK_TIMEOUT: ack wins, go to RESP.

Test Plan:
- LB at 0x1003, memRdata=0x80FF_1234, ack on 1st cycle -> memBe=1000, rspData=0xFFFF_FF80, rspValid 2 cycles after accept, rspError=0.
- LHU at 0x2002, memRdata=0xBEEF_0000, ack after 3 wait cycles -> memReq high 4 cycles, memBe=1100, rspData=0x0000_BEEF.
- SB at 0x10, writeData=0x1234_56AB -> memWe=1, memBe=0001, memWdata=0xABAB_ABAB, rspData=0, rspError=0.
- SW at 0x22 and LH at 0x101 -> no memReq, next-cycle rspValid=1, rspError=1; loadCtrl=011 gives the same response.
- ACK_TIMEOUT=4, LW with memAck held 0 -> memReq high 4 cycles, then ERR pulse, unit back in IDLE (reqReady=1).
- rstn=0 during ACCESS -> next edge memReq=0, busy=0, no rspValid; a following LW completes normally.
